// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined RV32I control decode carried through the ID/EX, EX/MM and MM/WB registers
module pipe_ctrl_unit #(
  parameter bit EXT_OPS   = 1'b1,
  parameter bit BR_EXT    = 1'b1,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opD,
  input  logic [2:0]           funct3D,
  input  logic                 funct7b5D,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [2:0]           ImmSrcD,
  output logic                 IllegalD,
  output logic                 RegWriteE,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcE,
  output logic [1:0]           ResultSrcM,
  output logic [1:0]           ResultSrcW,
  output logic                 MemWriteM,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcAE,
  output logic                 ALUSrcBE,
  output logic                 PCTargetSrcE,
  output logic                 PCSrcE,
  output logic                 IllegalE
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] funct3;
    alu_op_e    alu_ctrl;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       pc_target_src;
    logic       illegal;
  } idex_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } exmm_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mmwb_t;

  alu_op_e    alu_f3;
  idex_t      dec;
  logic [2:0] imm_src;
  logic       legal;
  logic       br_ok;
  idex_t      idex_d, idex_q;
  exmm_t      exmm_d, exmm_q;
  mmwb_t      mmwb_d, mmwb_q;
  logic       br_base;
  logic       taken;

  // Arithmetic op selected by funct3; funct7b5 only picks sra over srl here
  always_comb begin
    alu_f3 = ALU_ADD;
    case (funct3D)
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = funct7b5D ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      3'b111:  alu_f3 = ALU_AND;
      default: alu_f3 = ALU_ADD;
    endcase
  end

  // Main decoder: raw control word and legality of the current encoding
  always_comb begin
    dec     = '0;
    imm_src = 3'b000;
    legal   = 1'b0;
    br_ok   = (funct3D == 3'b000) ||
              (BR_EXT && (funct3D == 3'b001 || funct3D[2]));
    dec.funct3 = funct3D;
    case (opD)
      OP_LOAD: begin
        legal          = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src_b  = 1'b1;
      end
      OP_STORE: begin
        legal         = 1'b1;
        imm_src       = 3'b001;
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
      end
      OP_R: begin
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = (funct3D == 3'b000 && funct7b5D) ? ALU_SUB : alu_f3;
      end
      OP_I: begin
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_ctrl  = alu_f3;
      end
      OP_BRANCH: begin
        legal        = br_ok;
        imm_src      = 3'b010;
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        legal          = 1'b1;
        imm_src        = 3'b011;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
      end
      OP_LUI: begin
        legal          = EXT_OPS;
        imm_src        = 3'b100;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b11;
      end
      OP_AUIPC: begin
        legal         = EXT_OPS;
        imm_src       = 3'b100;
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
      end
      OP_JALR: begin
        legal             = EXT_OPS;
        dec.reg_write     = 1'b1;
        dec.result_src    = 2'b10;
        dec.jump          = 1'b1;
        dec.pc_target_src = 1'b1;
        dec.alu_src_b     = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings become an inert word tagged illegal; a flush discards the decode entirely
  always_comb begin
    ImmSrcD  = legal ? imm_src : 3'b000;
    IllegalD = ~legal;
    idex_d   = dec;
    if (!legal) begin
      idex_d         = '0;
      idex_d.illegal = 1'b1;
    end
    if (FlushE) idex_d = '0;
  end

  // Later stages only keep the writeback-related controls
  always_comb begin
    exmm_d.reg_write  = idex_q.reg_write;
    exmm_d.result_src = idex_q.result_src;
    exmm_d.mem_write  = idex_q.mem_write;
    mmwb_d.reg_write  = exmm_q.reg_write;
    mmwb_d.result_src = exmm_q.result_src;
  end

  // Pipeline registers; reset empties every stage at once
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= '0;
      exmm_q <= '0;
      mmwb_q <= '0;
    end else begin
      idex_q <= idex_d;
      exmm_q <= exmm_d;
      mmwb_q <= mmwb_d;
    end
  end

  // Branch resolution: funct3[2] picks the compare flavour, funct3[0] inverts, 010/011 never taken
  always_comb begin
    br_base = idex_q.funct3[2] ? (idex_q.funct3[1] ? LtuE : LtE) : ZeroE;
    taken   = (idex_q.funct3[2] | ~idex_q.funct3[1]) & (br_base ^ idex_q.funct3[0]);
    PCSrcE  = idex_q.jump | (idex_q.branch & taken);
  end

  assign RegWriteE    = idex_q.reg_write;
  assign ResultSrcE   = idex_q.result_src;
  assign ALUControlE  = ALUCTRL_W'(idex_q.alu_ctrl);
  assign ALUSrcAE     = idex_q.alu_src_a;
  assign ALUSrcBE     = idex_q.alu_src_b;
  assign PCTargetSrcE = idex_q.pc_target_src;
  assign IllegalE     = idex_q.illegal;
  assign RegWriteM    = exmm_q.reg_write;
  assign ResultSrcM   = exmm_q.result_src;
  assign MemWriteM    = exmm_q.mem_write;
  assign RegWriteW    = mmwb_q.reg_write;
  assign ResultSrcW   = mmwb_q.result_src;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: scoreboard bench for full and reduced pipe_ctrl_unit configurations
module tb_pipe_ctrl_unit;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                         BR = 7'b1100011, JAL = 7'b1101111, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, JALR = 7'b1100111;

  typedef struct packed {
    logic rw; logic [1:0] rs; logic mw; logic jump; logic branch; logic [2:0] f3;
    logic [3:0] alu; logic sa; logic sb; logic pts; logic ill; logic [2:0] imm;
  } ctrl_t;

  typedef struct packed {
    ctrl_t da; ctrl_t db; logic rst; logic flush; logic z; logic lt; logic ltu;
  } ent_t;

  typedef struct packed {
    logic [2:0] imm; logic illd; logic rwe; logic [1:0] rse; logic rwm; logic [1:0] rsm;
    logic mwm; logic rww; logic [1:0] rsw; logic [5:0] alu; logic sa; logic sb;
    logic pts; logic pcs; logic ille;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, FlushE, ZeroE, LtE, LtuE, funct7b5D;
  logic [6:0] opD;
  logic [2:0] funct3D;

  logic [2:0] a_imm, b_imm;
  logic a_illd, b_illd, a_rwe, b_rwe, a_rwm, b_rwm, a_rww, b_rww, a_mwm, b_mwm;
  logic [1:0] a_rse, b_rse, a_rsm, b_rsm, a_rsw, b_rsw;
  logic [3:0] a_alu;
  logic [5:0] b_alu;
  logic a_sa, b_sa, a_sb, b_sb, a_pts, b_pts, a_pcs, b_pcs, a_ille, b_ille;

  pipe_ctrl_unit dut_a (
    .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(a_imm), .IllegalD(a_illd),
    .RegWriteE(a_rwe), .RegWriteM(a_rwm), .RegWriteW(a_rww),
    .ResultSrcE(a_rse), .ResultSrcM(a_rsm), .ResultSrcW(a_rsw),
    .MemWriteM(a_mwm), .ALUControlE(a_alu), .ALUSrcAE(a_sa), .ALUSrcBE(a_sb),
    .PCTargetSrcE(a_pts), .PCSrcE(a_pcs), .IllegalE(a_ille)
  );

  pipe_ctrl_unit #(.EXT_OPS(1'b0), .BR_EXT(1'b0), .ALUCTRL_W(6)) dut_b (
    .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(b_imm), .IllegalD(b_illd),
    .RegWriteE(b_rwe), .RegWriteM(b_rwm), .RegWriteW(b_rww),
    .ResultSrcE(b_rse), .ResultSrcM(b_rsm), .ResultSrcW(b_rsw),
    .MemWriteM(b_mwm), .ALUControlE(b_alu), .ALUSrcAE(b_sa), .ALUSrcBE(b_sb),
    .PCTargetSrcE(b_pts), .PCSrcE(b_pcs), .IllegalE(b_ille)
  );

  obs_t obs [2];
  assign obs[0] = {a_imm, a_illd, a_rwe, a_rse, a_rwm, a_rsm, a_mwm, a_rww, a_rsw,
                   {2'b00, a_alu}, a_sa, a_sb, a_pts, a_pcs, a_ille};
  assign obs[1] = {b_imm, b_illd, b_rwe, b_rse, b_rwm, b_rsm, b_mwm, b_rww, b_rsw,
                   b_alu, b_sa, b_sb, b_pts, b_pcs, b_ille};

  ent_t q [$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // ALU op for register/immediate arithmetic by instruction name
  function automatic logic [3:0] arith(logic [2:0] f3, logic f7);
    case (f3)
      3'd0: return 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic taken(logic [2:0] f3, logic z, logic lt, logic ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Reference decode: expected control word for one instruction and one configuration
  function automatic ctrl_t model(bit ext, bit brx, logic [6:0] op, logic [2:0] f3, logic f7);
    ctrl_t c = '0;
    bit ok = 1'b1;
    c.f3 = f3;
    case (op)
      LW:    begin c.rw = 1; c.rs = 2'd1; c.sb = 1; end
      SW:    begin c.mw = 1; c.sb = 1; c.imm = 3'd1; end
      RT:    begin c.rw = 1; c.alu = (f3 == 3'd0 && f7) ? 4'd1 : arith(f3, f7); end
      IT:    begin c.rw = 1; c.sb = 1; c.alu = arith(f3, f7); end
      BR:    begin c.branch = 1; c.alu = 4'd1; c.imm = 3'd2;
                   ok = (f3 == 3'd0) || (brx && f3 != 3'd2 && f3 != 3'd3); end
      JAL:   begin c.rw = 1; c.rs = 2'd2; c.jump = 1; c.imm = 3'd3; end
      LUI:   begin ok = ext; c.rw = 1; c.rs = 2'd3; c.imm = 3'd4; end
      AUIPC: begin ok = ext; c.rw = 1; c.sa = 1; c.sb = 1; c.imm = 3'd4; end
      JALR:  begin ok = ext; c.rw = 1; c.rs = 2'd2; c.jump = 1; c.pts = 1; c.sb = 1; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      c = '0;
      c.ill = 1'b1;
    end
    return c;
  endfunction

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Drive one decode cycle and queue what both configurations should produce
  task automatic step(logic [6:0] op, logic [2:0] f3, logic f7, logic fl, logic rs,
                      logic z, logic lt, logic ltu);
    ent_t e;
    @(posedge clk);
    #1;
    opD = op; funct3D = f3; funct7b5D = f7; FlushE = fl; reset = rs;
    ZeroE = z; LtE = lt; LtuE = ltu;
    e.da = model(1'b1, 1'b1, op, f3, f7);
    e.db = model(1'b0, 1'b0, op, f3, f7);
    e.rst = rs; e.flush = fl; e.z = z; e.lt = lt; e.ltu = ltu;
    q.push_back(e);
  endtask

  ctrl_t pe [2] = '{default: '0};
  ctrl_t pm [2] = '{default: '0};
  ctrl_t pw [2] = '{default: '0};
  ent_t  e;
  ctrl_t dc;
  obs_t  ex;

  // Monitor: compare DUT outputs with the expected pipeline contents, then advance the model
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      for (int d = 0; d < 2; d++) begin
        dc = (d == 1) ? e.db : e.da;
        ex = {dc.imm, dc.ill, pe[d].rw, pe[d].rs, pm[d].rw, pm[d].rs, pm[d].mw,
              pw[d].rw, pw[d].rs, {2'b00, pe[d].alu}, pe[d].sa, pe[d].sb, pe[d].pts,
              pe[d].jump | (pe[d].branch & taken(pe[d].f3, e.z, e.lt, e.ltu)), pe[d].ill};
        chk("ImmSrcD", d, obs[d].imm, ex.imm);
        chk("IllegalD", d, obs[d].illd, ex.illd);
        chk("RegWriteE", d, obs[d].rwe, ex.rwe);
        chk("ResultSrcE", d, obs[d].rse, ex.rse);
        chk("RegWriteM", d, obs[d].rwm, ex.rwm);
        chk("ResultSrcM", d, obs[d].rsm, ex.rsm);
        chk("MemWriteM", d, obs[d].mwm, ex.mwm);
        chk("RegWriteW", d, obs[d].rww, ex.rww);
        chk("ResultSrcW", d, obs[d].rsw, ex.rsw);
        chk("ALUControlE", d, obs[d].alu, ex.alu);
        chk("ALUSrcAE", d, obs[d].sa, ex.sa);
        chk("ALUSrcBE", d, obs[d].sb, ex.sb);
        chk("PCTargetSrcE", d, obs[d].pts, ex.pts);
        chk("PCSrcE", d, obs[d].pcs, ex.pcs);
        chk("IllegalE", d, obs[d].ille, ex.ille);
        if (e.rst) begin
          pe[d] = '0; pm[d] = '0; pw[d] = '0;
        end else begin
          pw[d] = pm[d];
          pm[d] = pe[d];
          pe[d] = e.flush ? '0 : dc;
        end
      end
    end else if (!done) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expectation queued at %0t", $time);
    end
  end

  logic [6:0] ops [9] = '{LW, SW, RT, IT, BR, JAL, LUI, AUIPC, JALR};

  initial begin
    logic [6:0] op;
    reset = 1'b1; FlushE = 1'b0; ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    opD = LW; funct3D = 3'd2; funct7b5D = 1'b0;
    step(LW, 3'd2, 0, 0, 1, 0, 0, 0);
    step(LW, 3'd2, 0, 0, 1, 0, 0, 0);
    step(LW, 3'd2, 0, 0, 0, 0, 0, 0);
    repeat (3) step(IT, 3'd0, 0, 0, 0, 0, 0, 0);
    step(SW, 3'd2, 0, 0, 0, 0, 0, 0);
    repeat (3) step(IT, 3'd0, 0, 0, 0, 0, 0, 0);
    step(BR, 3'd0, 0, 0, 0, 0, 0, 0);
    step(IT, 3'd0, 0, 0, 0, 1, 0, 0);
    step(BR, 3'd1, 0, 0, 0, 0, 0, 0);
    step(IT, 3'd0, 0, 0, 0, 1, 0, 0);
    step(BR, 3'd4, 0, 0, 0, 0, 0, 0);
    step(IT, 3'd0, 0, 0, 0, 0, 1, 0);
    step(BR, 3'd7, 0, 0, 0, 0, 0, 0);
    step(IT, 3'd0, 0, 0, 0, 0, 0, 1);
    step(RT, 3'd0, 1, 0, 0, 0, 0, 0);
    step(IT, 3'd0, 1, 0, 0, 0, 0, 0);
    step(IT, 3'd5, 1, 0, 0, 0, 0, 0);
    step(LUI, 3'd0, 0, 0, 0, 0, 0, 0);
    step(JALR, 3'd0, 0, 0, 0, 0, 0, 0);
    step(AUIPC, 3'd0, 0, 0, 0, 0, 0, 0);
    step(LW, 3'd2, 0, 0, 0, 0, 0, 0);
    step(JAL, 3'd0, 0, 1, 0, 0, 0, 0);
    repeat (3) step(IT, 3'd0, 0, 0, 0, 0, 0, 0);
    step(7'h7f, 3'd0, 0, 0, 0, 0, 0, 0);
    step(LUI, 3'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(IT, 3'd0, 0, 0, 0, 0, 0, 0);
    step(LW, 3'd2, 0, 0, 0, 0, 0, 0);
    step(SW, 3'd2, 0, 0, 1, 0, 0, 0);
    repeat (3) step(IT, 3'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      step(op, 3'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    done = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
